// File: rtl/snake_gfx_pkg.sv
// Shared graphics types: RGB struct, named colours and the compositor's power-up palette.
package snake_gfx_pkg;

    localparam int COLOR_W = 8;

    typedef struct packed {
        logic [COLOR_W-1:0] r;
        logic [COLOR_W-1:0] g;
        logic [COLOR_W-1:0] b;
    } rgb_t;

    localparam rgb_t WHITE = '{r: {COLOR_W{1'b1}}, g: {COLOR_W{1'b1}}, b: {COLOR_W{1'b1}}};
    localparam rgb_t BLACK = '{r: {COLOR_W{1'b0}}, g: {COLOR_W{1'b0}}, b: {COLOR_W{1'b0}}};
    localparam rgb_t RED   = '{r: {COLOR_W{1'b1}}, g: {COLOR_W{1'b0}}, b: {COLOR_W{1'b0}}};
    localparam rgb_t GREEN = '{r: {COLOR_W{1'b0}}, g: {COLOR_W{1'b1}}, b: {COLOR_W{1'b0}}};
    localparam rgb_t BLUE  = '{r: {COLOR_W{1'b0}}, g: {COLOR_W{1'b0}}, b: {COLOR_W{1'b1}}};

    typedef enum logic [2:0] {
        COL_BLACK,
        COL_WHITE,
        COL_RED,
        COL_GREEN,
        COL_BLUE
    } color_name_e;

    // Colours are named rather than sized so that any channel width can expand them.
    function automatic color_name_e default_color(input int idx, input int num_layers);
        if (idx == num_layers) begin
            return COL_WHITE;
        end
        case (idx)
            0:       return COL_BLUE;
            1, 2:    return COL_RED;
            3:       return COL_GREEN;
            default: return COL_BLACK;
        endcase
    endfunction

    function automatic logic [2:0] color_mask(input color_name_e c);
        case (c)
            COL_WHITE: return 3'b111;
            COL_RED:   return 3'b100;
            COL_GREEN: return 3'b010;
            COL_BLUE:  return 3'b001;
            default:   return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/layer_priority_enc.sv
// Lowest-index-wins priority encoder over the effective layer hits.
module layer_priority_enc #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N + 1)
) (
    input  logic [N-1:0]     hits,
    output logic [IDX_W-1:0] idx,
    output logic             hit
);

    always_comb begin
        idx = '0;
        hit = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (hits[k]) begin
                idx = IDX_W'(k);
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/layer_compositor.sv
// Two-stage pixel compositor: priority select + blink/flash qualify, then palette lookup,
// inversion and blanking. Palette and blink counter live here.
module layer_compositor
    import snake_gfx_pkg::*;
#(
    parameter int NUM_LAYERS   = 4,
    parameter int COLOR_W      = 8,
    parameter int BLINK_FRAMES = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           display_enable_i,
    input  logic [NUM_LAYERS-1:0]          layer_gfx_i,
    input  logic [NUM_LAYERS-1:0]          layer_blink_i,
    input  logic                           frame_start_i,
    input  logic                           flash_i,
    input  logic                           pal_we_i,
    input  logic [$clog2(NUM_LAYERS+1)-1:0] pal_addr_i,
    input  logic [3*COLOR_W-1:0]           pal_data_i,
    output logic [COLOR_W-1:0]             r_o,
    output logic [COLOR_W-1:0]             g_o,
    output logic [COLOR_W-1:0]             b_o,
    output logic                           de_o
);

    localparam int AW    = $clog2(NUM_LAYERS + 1);
    localparam int PAL_W = 3 * COLOR_W;
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_FRAMES - 1);
    localparam logic [AW-1:0]    BG_IDX  = AW'(NUM_LAYERS);

    function automatic logic [PAL_W-1:0] expand(input color_name_e c);
        logic [2:0] m;
        m = color_mask(c);
        return {{COLOR_W{m[2]}}, {COLOR_W{m[1]}}, {COLOR_W{m[0]}}};
    endfunction

    logic [PAL_W-1:0]      pal [NUM_LAYERS+1];
    logic [CNT_W-1:0]      blink_cnt;
    logic                  blink_phase;
    logic [NUM_LAYERS-1:0] eff_hits;
    logic [AW-1:0]         enc_idx;
    logic                  enc_hit;
    logic [AW-1:0]         s1_idx;
    logic                  s1_de;
    logic                  s1_flash;
    logic [PAL_W-1:0]      lookup;

    // The palette resets with everything else so a mid-frame reset restores the defaults.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int e = 0; e <= NUM_LAYERS; e++) begin
                pal[e] <= expand(default_color(e, NUM_LAYERS));
            end
        end else if (pal_we_i && (pal_addr_i <= BG_IDX)) begin
            pal[pal_addr_i] <= pal_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_start_i) begin
            if (blink_cnt == CNT_MAX) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    assign eff_hits = layer_gfx_i & ~(layer_blink_i & {NUM_LAYERS{blink_phase}});

    layer_priority_enc #(
        .N     (NUM_LAYERS),
        .IDX_W (AW)
    ) u_enc (
        .hits (eff_hits),
        .idx  (enc_idx),
        .hit  (enc_hit)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_idx   <= '0;
            s1_de    <= 1'b0;
            s1_flash <= 1'b0;
        end else begin
            s1_idx   <= enc_hit ? enc_idx : BG_IDX;
            s1_de    <= display_enable_i;
            s1_flash <= flash_i & blink_phase;
        end
    end

    // Read before the write port updates, so a same-cycle write yields the old entry.
    assign lookup = pal[s1_idx];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_o  <= '0;
            g_o  <= '0;
            b_o  <= '0;
            de_o <= 1'b0;
        end else begin
            de_o <= s1_de;
            if (s1_de) begin
                {r_o, g_o, b_o} <= lookup ^ {PAL_W{s1_flash}};
            end else begin
                {r_o, g_o, b_o} <= '0;
            end
        end
    end

endmodule

// File: tb/tb_layer_compositor.sv
// Self-checking bench for layer_compositor: directed literal checks plus a random run
// against a behavioural model compared every cycle.
module tb_layer_compositor;
    import snake_gfx_pkg::*;

    localparam int NL = 4;
    localparam int CW = 8;
    localparam int BF = 2;
    localparam int AW = 3;
    localparam int PW = 3 * CW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          de_in = 1'b0;
    logic [NL-1:0] gfx = '0;
    logic [NL-1:0] blink = '0;
    logic          frame_start = 1'b0;
    logic          flash = 1'b0;
    logic          pal_we = 1'b0;
    logic [AW-1:0] pal_addr = '0;
    logic [PW-1:0] pal_data = '0;
    logic [CW-1:0] r, g, b;
    logic          de;

    always #5 clk = ~clk;

    layer_compositor #(
        .NUM_LAYERS   (NL),
        .COLOR_W      (CW),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .display_enable_i (de_in),
        .layer_gfx_i      (gfx),
        .layer_blink_i    (blink),
        .frame_start_i    (frame_start),
        .flash_i          (flash),
        .pal_we_i         (pal_we),
        .pal_addr_i       (pal_addr),
        .pal_data_i       (pal_data),
        .r_o              (r),
        .g_o              (g),
        .b_o              (b),
        .de_o             (de)
    );

    int n_checks = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Model state: palette contents, frame pulses seen, and the pixel waiting for lookup.
    logic [PW-1:0] mpal [NL+1];
    int            pulses;
    logic          p1_de;
    int            p1_idx;
    logic          p1_fl;
    logic [PW-1:0] exp_rgb;
    logic          exp_de;

    function automatic logic [PW-1:0] default_rgb(input int e);
        case (e)
            0:       return 24'h0000FF;
            1, 2:    return 24'hFF0000;
            3:       return 24'h00FF00;
            default: return 24'hFFFFFF;
        endcase
    endfunction

    task automatic model_reset();
        for (int e = 0; e <= NL; e++) mpal[e] = default_rgb(e);
        pulses  = 0;
        p1_de   = 1'b0;
        p1_idx  = NL;
        p1_fl   = 1'b0;
        exp_rgb = '0;
        exp_de  = 1'b0;
    endtask

    // Called just before the active edge with the inputs of this cycle.
    task automatic model_update();
        logic [PW-1:0] c;
        bit            ph;
        c = mpal[p1_idx];
        if (p1_fl) c = ~c;
        if (!p1_de) c = '0;
        exp_rgb = c;
        exp_de  = p1_de;
        if (pal_we && (int'(pal_addr) <= NL)) mpal[pal_addr] = pal_data;
        ph = ((pulses / BF) % 2) == 1;
        p1_idx = NL;
        for (int k = NL - 1; k >= 0; k--) begin
            if (gfx[k] && !(blink[k] && ph)) p1_idx = k;
        end
        p1_de = de_in;
        p1_fl = flash && ph;
        if (frame_start) pulses++;
    endtask

    task automatic step();
        model_update();
        @(negedge clk);
    endtask

    task automatic lit(input string nm, input logic [7:0] er, input logic [7:0] eg,
                       input logic [7:0] eb, input logic ede);
        n_checks++;
        if (r !== er || g !== eg || b !== eb || de !== ede) begin
            n_fail++;
            $display("FAIL %s: got rgb=(%0d,%0d,%0d) de=%b, want rgb=(%0d,%0d,%0d) de=%b",
                     nm, r, g, b, de, er, eg, eb, ede);
        end
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        step();
        step();
    endtask

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            n_checks++;
            if ({r, g, b} !== exp_rgb || de !== exp_de) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t: got rgb=%h de=%b, want rgb=%h de=%b",
                         $time, {r, g, b}, de, exp_rgb, exp_de);
            end
        end
    end

    initial begin
        model_reset();
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        lit("reset_state", 8'd0, 8'd0, 8'd0, 1'b0);
        rst_n = 1'b1;

        de_in = 1'b1; gfx = 4'b0000;
        step(); step();
        lit("background_white", 8'd255, 8'd255, 8'd255, 1'b1);
        de_in = 1'b0;
        step(); step();
        lit("blanking", 8'd0, 8'd0, 8'd0, 1'b0);

        de_in = 1'b1; gfx = 4'b1010;
        step(); step();
        lit("prio_1010", 8'd255, 8'd0, 8'd0, 1'b1);
        gfx = 4'b1001;
        step(); step();
        lit("prio_1001", 8'd0, 8'd0, 8'd255, 1'b1);
        gfx = 4'b1000;
        step(); step();
        lit("prio_1000", 8'd0, 8'd255, 8'd0, 1'b1);

        pal_we = 1'b1; pal_addr = 3'd3; pal_data = 24'h0A141E;
        step();
        lit("pal_same_cycle_old", 8'd0, 8'd255, 8'd0, 1'b1);
        pal_we = 1'b0;
        step();
        lit("pal_write_visible", 8'd10, 8'd20, 8'd30, 1'b1);

        gfx = 4'b0000; flash = 1'b1;
        step(); step();
        lit("flash_phase0", 8'd255, 8'd255, 8'd255, 1'b1);

        flash = 1'b0; blink = 4'b0001; gfx = 4'b0001;
        step(); step();
        lit("blink_frame0", 8'd0, 8'd0, 8'd255, 1'b1);
        pulse_frame();
        lit("blink_frame1", 8'd0, 8'd0, 8'd255, 1'b1);
        pulse_frame();
        lit("blink_frame2", 8'd255, 8'd255, 8'd255, 1'b1);
        pulse_frame();
        lit("blink_frame3", 8'd255, 8'd255, 8'd255, 1'b1);
        pulse_frame();
        lit("blink_frame4", 8'd0, 8'd0, 8'd255, 1'b1);

        pulse_frame();
        pulse_frame();
        blink = 4'b0000; gfx = 4'b0000; flash = 1'b1;
        step(); step();
        lit("flash_phase1_bg", 8'd0, 8'd0, 8'd0, 1'b1);
        gfx = 4'b0001;
        step(); step();
        lit("flash_phase1_blue", 8'd255, 8'd255, 8'd0, 1'b1);
        flash = 1'b0;

        pal_we = 1'b1; pal_addr = 3'd0; pal_data = 24'h123456;
        step();
        pal_we = 1'b0;
        step(); step();
        lit("pre_reset_custom", 8'h12, 8'h34, 8'h56, 1'b1);
        rst_n = 1'b0;
        #1;
        lit("reset_async", 8'd0, 8'd0, 8'd0, 1'b0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(); step();
        lit("post_reset_palette", 8'd0, 8'd0, 8'd255, 1'b1);
        gfx = 4'b1000;
        step(); step();
        lit("post_reset_entry3", 8'd0, 8'd255, 8'd0, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            de_in       = ($urandom_range(0, 7) != 0);
            gfx         = 4'($urandom);
            if ((i % 400) == 0) blink = 4'($urandom);
            flash       = ($urandom_range(0, 3) == 0);
            frame_start = ($urandom_range(0, 15) == 0);
            pal_we      = ($urandom_range(0, 7) == 0);
            pal_addr    = 3'($urandom_range(0, 7));
            pal_data    = 24'($urandom);
            step();
        end
        de_in = 1'b0; pal_we = 1'b0; frame_start = 1'b0; flash = 1'b0;
        step(); step();
        chk_en = 1'b0;
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/layer_compositor.md
# layer_compositor

Parametrised, pipelined pixel compositor that takes N per-pixel layer hit flags from the sprite/border generators and produces the final RGB for the display controller. It replaces fixed-colour priority drawing with a run-time programmable palette, per-layer blinking and a full-screen flash effect. It sits between the graphics generators and the VGA/HDMI output, in the pixel-clock domain.

## Interface
Parameters:
- NUM_LAYERS, 4, number of layer hit inputs; index 0 has highest priority
- COLOR_W, 8, bits per colour channel
- BLINK_FRAMES, 16, frames per blink half-period; must be ≥1

Ports:
- clk_i  in  1  pixel clock
- rst_ni  in  1  asynchronous, active-low reset
- display_enable_i  in  1  active-video qualifier for the current pixel
- layer_gfx_i  in  NUM_LAYERS  per-layer hit flags for the current pixel
- layer_blink_i  in  NUM_LAYERS  per-layer blink enable mask (quasi-static)
- frame_start_i  in  1  one-cycle pulse at start of each frame
- flash_i  in  1  full-screen flash request (e.g. game over)
- pal_we_i  in  1  palette write strobe
- pal_addr_i  in  $clog2(NUM_LAYERS+1)  palette index; NUM_LAYERS = background
- pal_data_i  in  3*COLOR_W  {R,G,B} write data
- r_o, g_o, b_o  out  COLOR_W each  output colour
- de_o  out  1  display_enable_i delayed to align with r_o/g_o/b_o

## Operation
- Palette: NUM_LAYERS+1 entries of 3*COLOR_W. Reset values: entry 0 blue (0,0,max), entries 1–2 red (max,0,0), entry 3 green (0,max,0), entries 4..NUM_LAYERS-1 black, background entry white (max,max,max).
- Writes: pal_we_i=1 with pal_addr_i ≤ NUM_LAYERS writes entry at clock edge; addresses > NUM_LAYERS ignored.
- Blink counter: on frame_start_i, counter increments; at BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles. Reset: counter 0, phase 0.
- Layer effective hit = layer_gfx_i[k] & ~(layer_blink_i[k] & blink_phase).
- Selection: lowest-index effective hit wins; no hit → background entry.
- Flash: if flash_i (sampled with the pixel) and blink_phase=1, the selected colour is bitwise inverted on all channels.
- Blanking: display_enable_i=0 → r_o/g_o/b_o = 0 regardless of hits, flash or palette.

## Timing
- Two-stage pipeline, latency 2 cycles, throughput 1 pixel/cycle, no stalls.
- Stage 1 registers: selected index, display enable, flash qualifier (flash_i & blink_phase).
- Stage 2 registers: palette lookup, inversion, blanking → r_o/g_o/b_o, de_o.
- Reset values: r_o/g_o/b_o = 0, de_o = 0, pipeline registers 0/invalid.
- Palette write in cycle t is visible to stage-2 lookups in cycle t+1 onward; a lookup in cycle t reads the old value.
- Write to the entry being read in the same cycle: old value output, no glitch.
- blink_phase change at frame_start_i affects pixels entering stage 1 the following cycle; in-flight pixels keep their sampled phase.
- frame_start_i coincident with a palette write: both take effect independently.
- BLINK_FRAMES=1: phase toggles on every frame_start_i.
- Reset asserted mid-frame: all state, including the palette, returns to reset values asynchronously; output resumes 2 cycles after first valid pixel post-deassertion.

## Structure
- Shared package snake_gfx_pkg: rgb_t struct {r,g,b}, COLOR_W default, named colour constants (WHITE, BLACK, RED, GREEN, BLUE), default palette function indexed by entry.
- Sub-module layer_priority_enc: parametrised lowest-index-wins encoder returning index and a hit flag (combinational, used in stage 1).
- Blink counter and palette register file stay inline.

## Test plan
- Reset, DE=1, layer_gfx_i=4'b0000 → 2 cycles later RGB=(255,255,255), de_o=1; DE=0 → RGB=(0,0,0).
- layer_gfx_i=4'b1010 → RGB=(255,0,0) (layer 1 wins); 4'b1001 → (0,0,255); 4'b1000 → (0,255,0).
- Write entry 3 = (10,20,30), next cycle hit layer 3 only → (10,20,30); same-cycle read returns (0,255,0).
- BLINK_FRAMES=2, layer_blink_i=4'b0001, layer_gfx_i=4'b0001: frames 0–1 → blue, frames 2–3 → white background, frame 4 → blue.
- flash_i=1, blink_phase=1, no hits → RGB=(0,0,0) (inverted white); blink_phase=0 → (255,255,255).
- Assert rst_ni low mid-line after palette writes → outputs 0 immediately, palette back to defaults after release.
